// File: rtl/conv3x3_ctrl.sv
// conv3x3_ctrl: raster-scan 3x3 window sequencer feeding the adder9x averager.
// Optional feature: define CONV3X3_CTRL_ABORT_EN to add the abort input.
module conv3x3_ctrl #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 16,
  parameter int unsigned H = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] op1,
  output logic [N-1:0] op2,
  output logic [N-1:0] op3,
  output logic [N-1:0] op4,
  output logic [N-1:0] op5,
  output logic [N-1:0] op6,
  output logic [N-1:0] op7,
  output logic [N-1:0] op8,
  output logic [N-1:0] op9,
  output logic         win_valid,
  output logic         win_last,
  output logic         res_valid,
  output logic         busy,
  output logic         done
`ifdef CONV3X3_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          drain_cnt;
  logic          rv_d1;

  // Line buffers: line0 holds row r-2, line1 holds row r-1 at the current column.
  logic [N-1:0] line0 [W];
  logic [N-1:0] line1 [W];

  // Previous two window columns (index 0 is the older, leftmost one).
  logic [N-1:0] pt [2];
  logic [N-1:0] pm [2];
  logic [N-1:0] pb [2];

  logic [N-1:0] top_c;
  logic [N-1:0] mid_c;
  logic         kill;
  logic         accept;
  logic         emit;
  logic         last_pix;

  assign top_c = line0[col];
  assign mid_c = line1[col];

`ifdef CONV3X3_CTRL_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  assign accept   = in_valid && (state == RUN) && !kill;
  assign emit     = accept && (row >= ROW_TWO) && (col >= COL_TWO);
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

  // Pixel datapath: line buffer update and column shift, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      line0[col] <= mid_c;
      line1[col] <= in_data;
      pt[0]      <= pt[1];
      pt[1]      <= top_c;
      pm[0]      <= pm[1];
      pm[1]      <= mid_c;
      pb[0]      <= pb[1];
      pb[1]      <= in_data;
    end
  end

  // Frame FSM, raster counters, window outputs and result-valid delay pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      drain_cnt <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      rv_d1     <= 1'b0;
      res_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      op3       <= '0;
      op4       <= '0;
      op5       <= '0;
      op6       <= '0;
      op7       <= '0;
      op8       <= '0;
      op9       <= '0;
    end else begin
      done      <= 1'b0;
      win_valid <= emit;
      win_last  <= emit && last_pix;
      rv_d1     <= win_valid;
      res_valid <= rv_d1;
      if (emit) begin
        op1 <= pt[0];
        op2 <= pt[1];
        op3 <= top_c;
        op4 <= pm[0];
        op5 <= pm[1];
        op6 <= mid_c;
        op7 <= pb[0];
        op8 <= pb[1];
        op9 <= in_data;
      end
      if (kill) begin
        state     <= IDLE;
        col       <= '0;
        row       <= '0;
        drain_cnt <= 1'b0;
        in_ready  <= 1'b0;
        busy      <= 1'b0;
        win_valid <= 1'b0;
        win_last  <= 1'b0;
        rv_d1     <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= RUN;
              col      <= '0;
              row      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
          RUN: begin
            if (accept) begin
              if (last_pix) begin
                state     <= DRAIN;
                in_ready  <= 1'b0;
                drain_cnt <= 1'b0;
                col       <= '0;
                row       <= '0;
              end else if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
          DRAIN: begin
            if (drain_cnt) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              drain_cnt <= 1'b0;
            end else begin
              drain_cnt <= 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
